// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the character datapath:
// state encodings, user action codes and the VGA field widths.
package game_pkg;

    localparam int COLOUR_W = 6;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int WAIT_W   = 12;
    localparam int MOVE_W   = 8;

    // One-hot so each state maps directly onto its strobe output
    typedef enum logic [4:0] {
        S_INIT      = 5'b10000,
        S_IDLE      = 5'b01000,
        S_DRAW_MAP  = 5'b00100,
        S_APPLY     = 5'b00010,
        S_DRAW_CHAR = 5'b00001
    } state_e;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'b000,
        ACT_ATTACK = 3'b001,
        ACT_UP     = 3'b010,
        ACT_DOWN   = 3'b011,
        ACT_LEFT   = 3'b100,
        ACT_RIGHT  = 3'b101
    } action_e;

    function automatic logic is_action_code(input logic [2:0] code);
        return (code >= ACT_ATTACK) && (code <= ACT_RIGHT);
    endfunction

endpackage

// File: rtl/vga_arb.sv
// Zero-latency VGA write-port mux: the active drawer owns the port,
// otherwise the port is quiet and all fields read as zero.
module vga_arb
    import game_pkg::*;
(
    input  logic                sel_map_i,
    input  logic                sel_char_i,
    input  logic [X_W-1:0]      map_x_i,
    input  logic [Y_W-1:0]      map_y_i,
    input  logic [COLOUR_W-1:0] map_colour_i,
    input  logic                map_write_i,
    input  logic [X_W-1:0]      char_x_i,
    input  logic [Y_W-1:0]      char_y_i,
    input  logic [COLOUR_W-1:0] char_colour_i,
    input  logic                char_write_i,
    output logic [X_W-1:0]      vga_x_o,
    output logic [Y_W-1:0]      vga_y_o,
    output logic [COLOUR_W-1:0] vga_colour_o,
    output logic                vga_write_o
);

    // Select the drawer that currently owns the write port
    always_comb begin
        vga_x_o      = 9'd0;
        vga_y_o      = 8'd0;
        vga_colour_o = 6'd0;
        vga_write_o  = 1'b0;
        if (sel_map_i) begin
            vga_x_o      = map_x_i;
            vga_y_o      = map_y_i;
            vga_colour_o = map_colour_i;
            vga_write_o  = map_write_i;
        end else if (sel_char_i) begin
            vga_x_o      = char_x_i;
            vga_y_o      = char_y_i;
            vga_colour_o = char_colour_i;
            vga_write_o  = char_write_i;
        end else begin
            vga_write_o  = 1'b0;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Frame sequencer: init, wait for a frame tick, draw map, apply the user
// move every MOVE_DIV frames, draw character; with done timeouts and overrun flag.
module game_ctrl
    import game_pkg::*;
#(
    parameter int MOVE_DIV     = 4,
    parameter int DONE_TIMEOUT = 4095
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic [2:0]          user_input,
    input  logic [1:0]          collision,
    input  logic                map_done,
    input  logic                char_done,
    input  logic [X_W-1:0]      map_x,
    input  logic [Y_W-1:0]      map_y,
    input  logic [COLOUR_W-1:0] map_colour,
    input  logic                map_write,
    input  logic [X_W-1:0]      char_x,
    input  logic [Y_W-1:0]      char_y,
    input  logic [COLOUR_W-1:0] char_colour,
    input  logic                char_write,
    output logic                init,
    output logic                idle,
    output logic                apply_action,
    output logic                draw_map,
    output logic                draw_char,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write,
    output logic                frame_overrun,
    output logic                timeout_err
);

    localparam logic [MOVE_W-1:0] MOVE_LAST_C = MOVE_W'(MOVE_DIV - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C   = WAIT_W'(DONE_TIMEOUT);

    state_e              state_q;
    logic [MOVE_W-1:0]   move_cnt_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic                wait_hit_s;
    logic                apply_q;
    logic                overrun_q;
    logic                timeout_q;
    logic                move_ok_s;

    assign wait_d     = wait_q + 12'd1;
    assign wait_hit_s = (wait_d == TIMEOUT_C);
    assign move_ok_s  = (move_cnt_q == MOVE_LAST_C) && is_action_code(user_input)
                        && (collision == 2'b00);

    // Frame sequencer, move divider, done-wait counter and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_INIT;
            move_cnt_q <= 8'd0;
            wait_q     <= 12'd0;
            apply_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            apply_q <= 1'b0;
            if (frame_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_INIT: begin
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (frame_tick) begin
                        state_q <= S_DRAW_MAP;
                        wait_q  <= 12'd0;
                    end
                end
                S_DRAW_MAP: begin
                    wait_q <= wait_d;
                    if (map_done || wait_hit_s) begin
                        state_q <= S_APPLY;
                        apply_q <= move_ok_s;
                        if (!map_done) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_APPLY: begin
                    state_q    <= S_DRAW_CHAR;
                    wait_q     <= 12'd0;
                    move_cnt_q <= (move_cnt_q == MOVE_LAST_C) ? 8'd0 : move_cnt_q + 8'd1;
                end
                S_DRAW_CHAR: begin
                    wait_q <= wait_d;
                    if (char_done || wait_hit_s) begin
                        state_q <= S_IDLE;
                        if (!char_done) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign init          = (state_q == S_INIT);
    assign idle          = (state_q == S_IDLE);
    assign draw_map      = (state_q == S_DRAW_MAP);
    assign draw_char     = (state_q == S_DRAW_CHAR);
    assign apply_action  = apply_q;
    assign frame_overrun = overrun_q;
    assign timeout_err   = timeout_q;

    vga_arb u_vga_arb (
        .sel_map_i     (draw_map),
        .sel_char_i    (draw_char),
        .map_x_i       (map_x),
        .map_y_i       (map_y),
        .map_colour_i  (map_colour),
        .map_write_i   (map_write),
        .char_x_i      (char_x),
        .char_y_i      (char_y),
        .char_colour_i (char_colour),
        .char_write_i  (char_write),
        .vga_x_o       (vga_x),
        .vga_y_o       (vga_y),
        .vga_colour_o  (vga_colour),
        .vga_write_o   (vga_write)
    );

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter MOVE_DIV, default 4: frames per applied movement step (1..255).
REQ-002 SHALL have parameter DONE_TIMEOUT, default 4095: max cycles waited for a done pulse before a forced advance.
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports frame_tick in 1 (one-cycle start-of-frame pulse); user_input in 3 (000 none, 001 attack, 010 up, 011 down, 100 left, 101 right); collision in 2 (00 free, nonzero blocked).
REQ-006 SHALL have ports map_done in 1, char_done in 1: one-cycle completion pulses from the map drawer and the character drawer.
REQ-007 SHALL have map-side VGA inputs map_x in 9, map_y in 8, map_colour in 6, map_write in 1, and char-side inputs char_x in 9, char_y in 8, char_colour in 6, char_write in 1.
REQ-008 SHALL have outputs init, idle, apply_action, draw_map, draw_char, each 1 bit: one-hot state strobes to the datapaths.
REQ-009 SHALL have outputs vga_x 9, vga_y 8, vga_colour 6, vga_write 1: the arbitrated VGA write port.
REQ-010 SHALL have outputs frame_overrun 1 (sticky error flag) and timeout_err 1 (sticky error flag).

Function
REQ-011 SHALL implement FSM states S_INIT, S_IDLE, S_DRAW_MAP, S_APPLY, S_DRAW_CHAR.
REQ-012 S_INIT SHALL last exactly one cycle, assert init, then go to S_IDLE.
REQ-013 S_IDLE SHALL assert idle and go to S_DRAW_MAP on the cycle after frame_tick=1.
REQ-014 S_DRAW_MAP SHALL assert draw_map until map_done=1 and then go to S_APPLY.
REQ-015 S_APPLY SHALL last exactly one cycle, then go to S_DRAW_CHAR.
REQ-016 apply_action SHALL be 1 in S_APPLY only if move_cnt==MOVE_DIV-1, user_input is in 001..101, and collision==00.
REQ-017 move_cnt SHALL be an 8-bit counter incremented once per S_APPLY visit and wrapping to 0 after MOVE_DIV-1.
REQ-018 S_DRAW_CHAR SHALL assert draw_char until char_done=1 and then go to S_IDLE.
REQ-019 Exactly one of init/idle/draw_map/apply_action-window/draw_char SHALL be the state strobe at any time; apply_action SHALL never be asserted outside S_APPLY.
REQ-020 The VGA mux SHALL be combinational and zero-latency: in S_DRAW_MAP it passes the map_* inputs, in S_DRAW_CHAR it passes the char_* inputs, and otherwise vga_write=0 and x/y/colour=0.
REQ-021 A frame_tick arriving in any state other than S_IDLE SHALL be dropped and SHALL set frame_overrun=1 until reset.
REQ-022 A 12-bit wait counter SHALL clear on entry to S_DRAW_MAP and on entry to S_DRAW_CHAR and increment every cycle while in either state.
REQ-023 When the wait counter reaches DONE_TIMEOUT, the FSM SHALL advance as if the done pulse had occurred and SHALL set timeout_err=1 until reset.
REQ-024 A done pulse arriving in a state that does not wait for it SHALL be ignored.
REQ-025 frame_tick and a done pulse arriving in the same cycle SHALL be handled as the done transition plus an overrun.
REQ-026 Reset asserted mid-frame SHALL abort any drawing immediately, with the cycle after reset deassertion in S_INIT.

Reset
REQ-027 On reset, the FSM SHALL go to S_INIT.
REQ-028 On reset, move_cnt, the wait counter, frame_overrun and timeout_err SHALL be 0.
REQ-029 During reset, all strobe outputs SHALL be 0 except init=1, and vga_write=0.

Structure
REQ-030 State encodings, the user_input action codes and the colour width of 6 SHALL live in shared package game_pkg, also used by the character block.
REQ-031 The VGA mux SHALL be a separate sub-module vga_arb; the FSM and counters SHALL stay in game_ctrl.

Verification
REQ-032 Release reset -> init=1 for 1 cycle, then idle=1; vga_write=0 throughout.
REQ-033 MOVE_DIV=4, frame_tick, map_done after 10 cycles, user_input=010, collision=00, over 4 frames -> exactly one apply_action pulse, on the 4th frame.
REQ-034 Same as REQ-033 with collision=01 on the 4th frame -> no apply_action; move_cnt still wraps to 0.
REQ-035 map_write=1, map_x=100, char_x=5 while in S_DRAW_MAP -> vga_x=100 and vga_write=1 on the same cycle; in S_DRAW_CHAR the same stimulus gives vga_x=5.
REQ-036 No char_done with DONE_TIMEOUT=50 -> advance to S_IDLE after 50 cycles in S_DRAW_CHAR, timeout_err=1.
REQ-037 frame_tick during S_DRAW_MAP -> frame_overrun=1, FSM sequence unchanged; then reset mid-S_DRAW_CHAR -> S_INIT and both flags cleared.
